// File: rtl/or16_share_pkg.sv
// Shared types and constants for the or16_share_ctrl slice.
package or16_share_pkg;

   localparam int unsigned WIDTH = 16;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      RESP = 2'b10
   } state_t;

endpackage

// File: rtl/or16_bit.sv
// Existing 16-bit bitwise OR unit shared by the controller.
module or16_bit (
   input  logic [15:0] in0,
   input  logic [15:0] in1,
   output logic [15:0] out
);

   assign out = in0 | in1;

endmodule

// File: rtl/or16_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned ID_W = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [ID_W-1:0] ptr,
   output logic [NREQ-1:0] grant,
   output logic [ID_W-1:0] grant_id,
   output logic            any
);

   logic [ID_W-1:0] idx;

   // Scan requesters starting at ptr; index arithmetic wraps because NREQ is 2**ID_W.
   always_comb begin
      grant    = '0;
      grant_id = '0;
      any      = 1'b0;
      idx      = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = ptr + ID_W'(k);
         if (!any && req[idx]) begin
            any      = 1'b1;
            grant_id = idx;
         end
      end
      if (any) begin
         grant[grant_id] = 1'b1;
      end
   end

endmodule

// File: rtl/or16_share_ctrl.sv
// Round-robin front end that time-shares one or16_bit unit among NREQ requesters.
module or16_share_ctrl
   import or16_share_pkg::*;
#(
   parameter int unsigned NREQ = 4,
   parameter int unsigned ID_W = 2
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   output logic [NREQ-1:0]       req_ready,
   output logic                  resp_valid,
   output logic [ID_W-1:0]       resp_id,
   output logic [WIDTH-1:0]      resp_data,
   input  logic                  resp_ready,
   output logic [15:0]           txn_count
);

   localparam int unsigned CNT_W = 16;

   state_t          state;
   state_t          state_d;
   logic [ID_W-1:0] rr_ptr;
   logic [ID_W-1:0] id_q;
   logic [ID_W-1:0] arb_id;
   logic [NREQ-1:0] arb_grant;
   logic            arb_any;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] sel_a;
   logic [WIDTH-1:0] sel_b;
   logic [WIDTH-1:0] or_out;
   logic            grant_en;
   logic            calc_en;
   logic            done_en;

   rr_arbiter #(
      .NREQ (NREQ),
      .ID_W (ID_W)
   ) u_arb (
      .req      (req_valid),
      .ptr      (rr_ptr),
      .grant    (arb_grant),
      .grant_id (arb_id),
      .any      (arb_any)
   );

   or16_bit u_or (
      .in0 (op_a),
      .in1 (op_b),
      .out (or_out)
   );

   // State register; illegal encodings fall into the default branch below.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_d;
      end
   end

   // Next state, combinational grant and per-state datapath enables.
   always_comb begin
      state_d   = IDLE;
      req_ready = '0;
      grant_en  = 1'b0;
      calc_en   = 1'b0;
      done_en   = 1'b0;
      case (state)
         IDLE: begin
            req_ready = reset_n ? arb_grant : '0;
            if (arb_any) begin
               grant_en = 1'b1;
               state_d  = CALC;
            end
         end
         CALC: begin
            calc_en = 1'b1;
            state_d = RESP;
         end
         RESP: begin
            if (resp_ready) begin
               done_en = 1'b1;
            end else begin
               state_d = RESP;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Pick the winner's operand slices out of the packed request buses.
   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (arb_id == ID_W'(k)) begin
            sel_a = req_a[k*WIDTH +: WIDTH];
            sel_b = req_b[k*WIDTH +: WIDTH];
         end
      end
   end

   // Operand, response and transaction-count registers.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rr_ptr     <= '0;
         id_q       <= '0;
         op_a       <= '0;
         op_b       <= '0;
         resp_valid <= 1'b0;
         resp_id    <= '0;
         resp_data  <= '0;
         txn_count  <= '0;
      end else begin
         if (grant_en) begin
            op_a   <= sel_a;
            op_b   <= sel_b;
            id_q   <= arb_id;
            rr_ptr <= arb_id + ID_W'(1);
         end
         if (calc_en) begin
            resp_data  <= or_out;
            resp_id    <= id_q;
            resp_valid <= 1'b1;
         end
         if (done_en) begin
            resp_valid <= 1'b0;
            txn_count  <= txn_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_or16_share_ctrl.sv
// Self-checking bench for or16_share_ctrl against a round-robin reference model.
module tb_or16_share_ctrl;

   logic        clk;
   logic        reset_n;
   logic [3:0]  req_valid;
   logic [63:0] req_a;
   logic [63:0] req_b;
   logic [3:0]  req_ready;
   logic        resp_valid;
   logic [1:0]  resp_id;
   logic [15:0] resp_data;
   logic        resp_ready;
   logic [15:0] txn_count;

   int          n_cmp;
   int          n_bad;
   int          m_ptr;
   logic [15:0] m_cnt;

   or16_share_ctrl #(
      .NREQ (4),
      .ID_W (2)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .req_valid  (req_valid),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_ready  (req_ready),
      .resp_valid (resp_valid),
      .resp_id    (resp_id),
      .resp_data  (resp_data),
      .resp_ready (resp_ready),
      .txn_count  (txn_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
      req_a[i*16 +: 16] = a;
      req_b[i*16 +: 16] = b;
   endtask

   task automatic rand_ops();
      req_a = {$urandom, $urandom};
      req_b = {$urandom, $urandom};
   endtask

   // Reference arbitration: first valid requester scanning from the model pointer.
   function automatic int model_winner(input logic [3:0] v);
      for (int k = 0; k < 4; k++) begin
         int i;
         i = (m_ptr + k) % 4;
         if (v[i]) return i;
      end
      return -1;
   endfunction

   function automatic logic [3:0] onehot(input int w);
      logic [3:0] r;
      r = '0;
      if (w >= 0) r[w] = 1'b1;
      return r;
   endfunction

   function automatic logic [15:0] op_or(input int i);
      return req_a[i*16 +: 16] | req_b[i*16 +: 16];
   endfunction

   task automatic do_reset();
      reset_n    = 1'b0;
      req_valid  = '0;
      resp_ready = 1'b0;
      cycle();
      cycle();
      reset_n = 1'b1;
      m_ptr   = 0;
      m_cnt   = '0;
   endtask

   task automatic test_reset();
      reset_n    = 1'b0;
      req_valid  = 4'b1111;
      rand_ops();
      resp_ready = 1'b1;
      cycle();
      cycle();
      @(negedge clk);
      n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
      n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
      n_cmp++; if (resp_id !== 2'd0) begin n_bad++; $display("FAIL reset_resp_id: got %0d want 0", resp_id); end
      n_cmp++; if (resp_data !== 16'h0000) begin n_bad++; $display("FAIL reset_resp_data: got %h want 0000", resp_data); end
      n_cmp++; if (txn_count !== 16'h0000) begin n_bad++; $display("FAIL reset_txn_count: got %h want 0000", txn_count); end
      req_valid = '0;
      cycle();
      reset_n    = 1'b1;
      resp_ready = 1'b0;
      m_ptr      = 0;
      m_cnt      = '0;
   endtask

   // Directed single transactions: plain operand and all-ones operand.
   task automatic test_single();
      int          idx [2];
      logic [15:0] av  [2];
      logic [15:0] bv  [2];
      idx = '{0, 2};
      av  = '{16'h02F3, 16'h02F3};
      bv  = '{16'h0000, 16'hFFFF};
      for (int t = 0; t < 2; t++) begin
         int          w;
         logic [15:0] exp_d;
         req_valid = onehot(idx[t]);
         rand_ops();
         set_op(idx[t], av[t], bv[t]);
         resp_ready = 1'b0;
         @(negedge clk);
         w = model_winner(req_valid);
         n_cmp++; if (req_ready !== onehot(w)) begin n_bad++; $display("FAIL single_grant[%0d]: got %b want %b", t, req_ready, onehot(w)); end
         exp_d = op_or(w);
         m_ptr = (w + 1) % 4;
         cycle();
         req_valid = '0;
         @(negedge clk);
         n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL single_calc_valid[%0d]: got %b want 0", t, resp_valid); end
         cycle();
         resp_ready = 1'b1;
         @(negedge clk);
         n_cmp++; if (resp_valid !== 1'b1) begin n_bad++; $display("FAIL single_resp_valid[%0d]: got %b want 1", t, resp_valid); end
         n_cmp++; if (resp_data !== exp_d) begin n_bad++; $display("FAIL single_resp_data[%0d]: got %h want %h", t, resp_data, exp_d); end
         n_cmp++; if (resp_id !== 2'(w)) begin n_bad++; $display("FAIL single_resp_id[%0d]: got %0d want %0d", t, resp_id, w); end
         cycle();
         resp_ready = 1'b0;
         m_cnt      = m_cnt + 16'd1;
         @(negedge clk);
         n_cmp++; if (txn_count !== m_cnt) begin n_bad++; $display("FAIL single_txn_count[%0d]: got %h want %h", t, txn_count, m_cnt); end
         n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL single_resp_drop[%0d]: got %b want 0", t, resp_valid); end
         cycle();
      end
   endtask

   task automatic test_round_robin();
      do_reset();
      req_valid  = 4'b1111;
      rand_ops();
      resp_ready = 1'b1;
      for (int g = 0; g < 4; g++) begin
         int          w;
         logic [15:0] exp_d;
         @(negedge clk);
         w = model_winner(req_valid);
         n_cmp++; if (req_ready !== onehot(w)) begin n_bad++; $display("FAIL rr_grant[%0d]: got %b want %b", g, req_ready, onehot(w)); end
         exp_d = op_or(w);
         m_ptr = (w + 1) % 4;
         cycle();
         if (w >= 0) req_valid[w] = 1'b0;
         @(negedge clk);
         n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL rr_calc_ready[%0d]: got %b want 0000", g, req_ready); end
         cycle();
         @(negedge clk);
         n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL rr_resp_ready[%0d]: got %b want 0000", g, req_ready); end
         n_cmp++; if (resp_data !== exp_d) begin n_bad++; $display("FAIL rr_resp_data[%0d]: got %h want %h", g, resp_data, exp_d); end
         n_cmp++; if (resp_id !== 2'(w)) begin n_bad++; $display("FAIL rr_resp_id[%0d]: got %0d want %0d", g, resp_id, w); end
         cycle();
         m_cnt = m_cnt + 16'd1;
      end
      resp_ready = 1'b0;
      @(negedge clk);
      n_cmp++; if (txn_count !== m_cnt) begin n_bad++; $display("FAIL rr_txn_count: got %h want %h", txn_count, m_cnt); end
      cycle();
   endtask

   task automatic test_backpressure();
      int          w;
      logic [15:0] exp_d;
      req_valid  = 4'b0001;
      rand_ops();
      resp_ready = 1'b0;
      @(negedge clk);
      w = model_winner(req_valid);
      n_cmp++; if (req_ready !== onehot(w)) begin n_bad++; $display("FAIL bp_grant0: got %b want %b", req_ready, onehot(w)); end
      exp_d = op_or(w);
      m_ptr = (w + 1) % 4;
      cycle();
      req_valid = 4'b0110;
      cycle();
      for (int s = 0; s < 5; s++) begin
         @(negedge clk);
         n_cmp++; if (resp_valid !== 1'b1) begin n_bad++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", s, resp_valid); end
         n_cmp++; if (resp_data !== exp_d) begin n_bad++; $display("FAIL bp_hold_data[%0d]: got %h want %h", s, resp_data, exp_d); end
         n_cmp++; if (resp_id !== 2'(w)) begin n_bad++; $display("FAIL bp_hold_id[%0d]: got %0d want %0d", s, resp_id, w); end
         n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL bp_hold_ready[%0d]: got %b want 0000", s, req_ready); end
         cycle();
      end
      resp_ready = 1'b1;
      cycle();
      resp_ready = 1'b0;
      m_cnt      = m_cnt + 16'd1;
      @(negedge clk);
      w = model_winner(req_valid);
      n_cmp++; if (req_ready !== onehot(w)) begin n_bad++; $display("FAIL bp_next_grant: got %b want %b", req_ready, onehot(w)); end
      exp_d = op_or(w);
      m_ptr = (w + 1) % 4;
      cycle();
      req_valid = '0;
      cycle();
      resp_ready = 1'b1;
      @(negedge clk);
      n_cmp++; if (resp_data !== exp_d) begin n_bad++; $display("FAIL bp_next_data: got %h want %h", resp_data, exp_d); end
      n_cmp++; if (resp_id !== 2'(w)) begin n_bad++; $display("FAIL bp_next_id: got %0d want %0d", resp_id, w); end
      cycle();
      resp_ready = 1'b0;
      m_cnt      = m_cnt + 16'd1;
      @(negedge clk);
      n_cmp++; if (txn_count !== m_cnt) begin n_bad++; $display("FAIL bp_txn_count: got %h want %h", txn_count, m_cnt); end
      cycle();
   endtask

   task automatic test_reset_mid();
      int          w;
      logic [15:0] exp_d;
      req_valid  = 4'b1000;
      rand_ops();
      resp_ready = 1'b1;
      @(negedge clk);
      w = model_winner(req_valid);
      n_cmp++; if (req_ready !== onehot(w)) begin n_bad++; $display("FAIL rm_grant: got %b want %b", req_ready, onehot(w)); end
      cycle();
      reset_n   = 1'b0;
      req_valid = 4'b1111;
      cycle();
      m_ptr = 0;
      m_cnt = '0;
      @(negedge clk);
      n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL rm_resp_valid: got %b want 0", resp_valid); end
      n_cmp++; if (resp_data !== 16'h0000) begin n_bad++; $display("FAIL rm_resp_data: got %h want 0000", resp_data); end
      n_cmp++; if (txn_count !== m_cnt) begin n_bad++; $display("FAIL rm_txn_count: got %h want %h", txn_count, m_cnt); end
      n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL rm_req_ready: got %b want 0000", req_ready); end
      cycle();
      reset_n   = 1'b1;
      req_valid = 4'b1010;
      rand_ops();
      for (int t = 0; t < 2; t++) begin
         @(negedge clk);
         w = model_winner(req_valid);
         n_cmp++; if (req_ready !== onehot(w)) begin n_bad++; $display("FAIL rm_post_grant[%0d]: got %b want %b", t, req_ready, onehot(w)); end
         exp_d = op_or(w);
         m_ptr = (w + 1) % 4;
         cycle();
         if (w >= 0) req_valid[w] = 1'b0;
         cycle();
         @(negedge clk);
         n_cmp++; if (resp_data !== exp_d) begin n_bad++; $display("FAIL rm_post_data[%0d]: got %h want %h", t, resp_data, exp_d); end
         n_cmp++; if (resp_id !== 2'(w)) begin n_bad++; $display("FAIL rm_post_id[%0d]: got %0d want %0d", t, resp_id, w); end
         cycle();
         m_cnt = m_cnt + 16'd1;
      end
      resp_ready = 1'b0;
      @(negedge clk);
      n_cmp++; if (txn_count !== m_cnt) begin n_bad++; $display("FAIL rm_post_count: got %h want %h", txn_count, m_cnt); end
      cycle();
   endtask

   task automatic test_random();
      for (int it = 0; it < 60; it++) begin
         int          w;
         int          stall;
         logic [15:0] exp_d;
         req_valid  = 4'($urandom_range(0, 15));
         rand_ops();
         resp_ready = 1'b0;
         stall      = $urandom_range(0, 3);
         @(negedge clk);
         n_cmp++; if (txn_count !== m_cnt) begin n_bad++; $display("FAIL rnd_count[%0d]: got %h want %h", it, txn_count, m_cnt); end
         w = model_winner(req_valid);
         n_cmp++; if (req_ready !== onehot(w)) begin n_bad++; $display("FAIL rnd_grant[%0d]: got %b want %b (valid %b)", it, req_ready, onehot(w), req_valid); end
         if (w < 0) begin
            cycle();
            continue;
         end
         exp_d = op_or(w);
         m_ptr = (w + 1) % 4;
         cycle();
         req_valid[w] = 1'b0;
         rand_ops();
         @(negedge clk);
         n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL rnd_calc_ready[%0d]: got %b want 0000", it, req_ready); end
         cycle();
         for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            n_cmp++; if (resp_valid !== 1'b1 || req_ready !== 4'b0000) begin n_bad++; $display("FAIL rnd_stall[%0d]: got valid %b ready %b want 1 0000", it, resp_valid, req_ready); end
            cycle();
         end
         resp_ready = 1'b1;
         @(negedge clk);
         n_cmp++; if (resp_valid !== 1'b1) begin n_bad++; $display("FAIL rnd_resp_valid[%0d]: got %b want 1", it, resp_valid); end
         n_cmp++; if (resp_data !== exp_d) begin n_bad++; $display("FAIL rnd_resp_data[%0d]: got %h want %h", it, resp_data, exp_d); end
         n_cmp++; if (resp_id !== 2'(w)) begin n_bad++; $display("FAIL rnd_resp_id[%0d]: got %0d want %0d", it, resp_id, w); end
         cycle();
         m_cnt = m_cnt + 16'd1;
      end
      req_valid  = '0;
      resp_ready = 1'b0;
      cycle();
   endtask

   task automatic test_wrap();
      int          w;
      logic [15:0] exp_d;
      req_valid = '0;
      force dut.txn_count = 16'hFFFF;
      @(negedge clk);
      release dut.txn_count;
      m_cnt = 16'hFFFF;
      cycle();
      @(negedge clk);
      n_cmp++; if (txn_count !== m_cnt) begin n_bad++; $display("FAIL wrap_preload: got %h want %h", txn_count, m_cnt); end
      cycle();
      req_valid  = onehot($urandom_range(0, 3));
      rand_ops();
      resp_ready = 1'b1;
      @(negedge clk);
      w = model_winner(req_valid);
      n_cmp++; if (req_ready !== onehot(w)) begin n_bad++; $display("FAIL wrap_grant: got %b want %b", req_ready, onehot(w)); end
      exp_d = op_or(w);
      m_ptr = (w + 1) % 4;
      cycle();
      req_valid = '0;
      cycle();
      @(negedge clk);
      n_cmp++; if (resp_data !== exp_d) begin n_bad++; $display("FAIL wrap_data: got %h want %h", resp_data, exp_d); end
      cycle();
      resp_ready = 1'b0;
      m_cnt      = m_cnt + 16'd1;
      @(negedge clk);
      n_cmp++; if (txn_count !== m_cnt) begin n_bad++; $display("FAIL wrap_count: got %h want %h", txn_count, m_cnt); end
      cycle();
   endtask

   initial begin
      n_cmp      = 0;
      n_bad      = 0;
      m_ptr      = 0;
      m_cnt      = '0;
      reset_n    = 1'b0;
      req_valid  = '0;
      req_a      = '0;
      req_b      = '0;
      resp_ready = 1'b0;
      cycle();
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_reset_mid();
      test_random();
      test_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
